// File: rtl/shift_sequencer.sv
// -----------------------------------------------------------------------------
// shift_sequencer
//
// Command-driven controller for one 8-bit load/shift-right register.
// A command {operand, shift amount, arithmetic flag} is accepted over a
// valid/ready handshake. The block then drives the shifter's load, shift and
// ASR controls for the exact number of cycles. It captures the shifter output
// and returns it over a second valid/ready handshake.
//
// Handshake rule (both channels): a transfer happens on the rising clk edge
// where valid && ready are both high. Once valid is raised it is held, and its
// payload is held stable, until that edge. The ready signal may be high or low
// regardless of valid.
//
// Optional feature: define SHIFT_SEQ_ABORT_EN to add the 'abort' input. Abort
// cancels an operation in LOAD/SHIFT/CAPT with no response.
//
// Ports:
//   clk            in   system clock, rising edge, shared with the shifter
//   reset          in   asynchronous active-high reset
//   cmd_valid      in   command present
//   cmd_ready      out  command accepted when cmd_valid && cmd_ready (IDLE only)
//   cmd_data       in   operand
//   cmd_amt        in   number of right shifts (modulo 2^AMT_W)
//   cmd_arith      in   1 = sign fill, 0 = zero fill
//   sh_load_val    out  shifter LoadVal
//   sh_load_n      out  shifter Load_n (active low)
//   sh_shift_right out  shifter ShiftRight
//   sh_asr         out  shifter ASR
//   sh_q           in   shifter output
//   res_valid      out  result available
//   res_ready      in   result consumed when res_valid && res_ready
//   res_data       out  captured result
//   busy           out  high in any state other than IDLE
//   abort          in   (SHIFT_SEQ_ABORT_EN only) cancel current operation
// -----------------------------------------------------------------------------
module shift_sequencer #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [AMT_W-1:0] cmd_amt,
    input  logic             cmd_arith,
    output logic [WIDTH-1:0] sh_load_val,
    output logic             sh_load_n,
    output logic             sh_shift_right,
    output logic             sh_asr,
    input  logic [WIDTH-1:0] sh_q,
`ifdef SHIFT_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SHIFT = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    localparam logic [AMT_W-1:0] AMT_ONE = AMT_W'(1);

    state_t           state;
    logic [AMT_W-1:0] count;

    // The only combinational output. It is masked by reset so that no command
    // is seen as accepted while reset is held.
    assign cmd_ready = (state == IDLE) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            count          <= '0;
            sh_load_val    <= '0;
            sh_load_n      <= 1'b1;
            sh_shift_right <= 1'b0;
            sh_asr         <= 1'b0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            busy           <= 1'b0;
        end else begin
`ifdef SHIFT_SEQ_ABORT_EN
            if (abort && (state == LOAD || state == SHIFT || state == CAPT)) begin
                state          <= IDLE;
                count          <= '0;
                sh_load_val    <= '0;
                sh_load_n      <= 1'b1;
                sh_shift_right <= 1'b0;
                sh_asr         <= 1'b0;
                busy           <= 1'b0;
            end else
`endif
            begin
                case (state)
                    IDLE: begin
                        if (cmd_valid) begin
                            // load_val and asr stay frozen until the next
                            // accept. The shifter takes its ASR fill bit from
                            // LoadVal[MSB], so changing them mid-shift would
                            // corrupt the fill.
                            sh_load_val <= cmd_data;
                            sh_asr      <= cmd_arith;
                            count       <= cmd_amt;
                            sh_load_n   <= 1'b0;
                            busy        <= 1'b1;
                            state       <= LOAD;
                        end
                    end
                    LOAD: begin
                        // The shifter loads on this edge.
                        sh_load_n <= 1'b1;
                        if (count != '0) begin
                            sh_shift_right <= 1'b1;
                            state          <= SHIFT;
                        end else begin
                            state <= CAPT;
                        end
                    end
                    SHIFT: begin
                        // One shift per edge. Leave after the count-th shift.
                        count <= count - AMT_ONE;
                        if (count == AMT_ONE) begin
                            sh_shift_right <= 1'b0;
                            state          <= CAPT;
                        end
                    end
                    CAPT: begin
                        res_data  <= sh_q;
                        res_valid <= 1'b1;
                        state     <= RESP;
                    end
                    RESP: begin
                        if (res_ready) begin
                            res_valid <= 1'b0;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// -----------------------------------------------------------------------------
// tb_shift_sequencer
//
// Bench for shift_sequencer with a behavioural model of the 8-bit
// load/shift-right register. Directed vectors carry hand-computed results.
// Hand-written sequences cover reset in mid-operation and abort.
// -----------------------------------------------------------------------------
module tb_shift_sequencer;

    localparam int WIDTH = 8;
    localparam int AMT_W = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [AMT_W-1:0] cmd_amt;
    logic             cmd_arith;
    logic [WIDTH-1:0] sh_load_val;
    logic             sh_load_n;
    logic             sh_shift_right;
    logic             sh_asr;
    logic [WIDTH-1:0] sh_q;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
`ifdef SHIFT_SEQ_ABORT_EN
    logic             abort;
`endif

    shift_sequencer #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .cmd_amt        (cmd_amt),
        .cmd_arith      (cmd_arith),
        .sh_load_val    (sh_load_val),
        .sh_load_n      (sh_load_n),
        .sh_shift_right (sh_shift_right),
        .sh_asr         (sh_asr),
        .sh_q           (sh_q),
`ifdef SHIFT_SEQ_ABORT_EN
        .abort          (abort),
`endif
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_data       (res_data),
        .busy           (busy)
    );

    // ---------------- shifter model ----------------
    // Load has priority. Otherwise shift right, with the fill bit taken from
    // LoadVal[MSB] when ASR is set.
    always_ff @(posedge clk) begin
        if (!sh_load_n)
            sh_q <= sh_load_val;
        else if (sh_shift_right)
            sh_q <= {(sh_asr ? sh_load_val[WIDTH-1] : 1'b0), sh_q[WIDTH-1:1]};
    end

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fails  = 0;
    logic [WIDTH-1:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " cmd_ready"},   32'(cmd_ready),      32'd0);
        chk({tag, " res_valid"},   32'(res_valid),      32'd0);
        chk({tag, " res_data"},    32'(res_data),       32'd0);
        chk({tag, " load_val"},    32'(sh_load_val),    32'd0);
        chk({tag, " load_n"},      32'(sh_load_n),      32'd1);
        chk({tag, " shift_right"}, 32'(sh_shift_right), 32'd0);
        chk({tag, " asr"},         32'(sh_asr),         32'd0);
        chk({tag, " busy"},        32'(busy),           32'd0);
    endtask

    // Present a command at a negedge and return once the accepting edge (E0)
    // has passed. Inputs are left applied.
    task automatic send_cmd(input logic [7:0] d, input logic [2:0] a, input logic ar,
                            input string tag);
        bit got;
        got = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_amt   = a;
        cmd_arith = ar;
        for (int i = 0; i < 20; i++) begin
            got = cmd_ready;
            @(posedge clk);
            if (got) break;
            @(negedge clk);
        end
        chk({tag, " accepted"}, 32'(got), 32'd1);
    endtask

    // Full transaction with latency, shift-count and hold checks.
    // hold=1 keeps res_ready low for 5 cycles after res_valid rises.
    task automatic run_cmd(input logic [7:0] d, input logic [2:0] a, input logic ar,
                           input logic hold, input string tag);
        int k, shifts, loads;
        bit seen, held_ok;
        logic [7:0] exp;
        res_ready = !hold;
        send_cmd(d, a, ar, tag);
        @(negedge clk);
        cmd_valid = 1'b0;
        k = 1; shifts = 0; loads = 0; seen = 1'b0; held_ok = 1'b1;
        while (k < 40) begin
            if (sh_shift_right) shifts++;
            if (!sh_load_n) loads++;
            if (sh_load_val !== d || sh_asr !== ar) held_ok = 1'b0;
            if (res_valid) begin
                seen = 1'b1;
                break;
            end
            k++;
            @(negedge clk);
        end
        chk({tag, " res_valid seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"},        32'(k),      32'(int'(a) + 3));
        chk({tag, " shift cycles"},   32'(shifts), 32'(a));
        chk({tag, " load cycles"},    32'(loads),  32'd1);
        chk({tag, " operand held"},   32'(held_ok), 32'd1);
        exp = exp_q.pop_front();
        chk({tag, " res_data"},       32'(res_data), 32'(exp));
        chk({tag, " busy in RESP"},   32'(busy),      32'd1);
        chk({tag, " cmd_ready RESP"}, 32'(cmd_ready), 32'd0);
        if (hold) begin
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                chk({tag, " bp res_valid"}, 32'(res_valid), 32'd1);
                chk({tag, " bp res_data"},  32'(res_data),  32'(exp));
                chk({tag, " bp cmd_ready"}, 32'(cmd_ready), 32'd0);
                chk({tag, " bp busy"},      32'(busy),      32'd1);
            end
            res_ready = 1'b1;
        end
        @(negedge clk);
        chk({tag, " res_valid drop"}, 32'(res_valid), 32'd0);
        chk({tag, " busy drop"},      32'(busy),      32'd0);
        chk({tag, " cmd_ready back"}, 32'(cmd_ready), 32'd1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0] data;
        logic [2:0] amt;
        logic       arith;
        logic       hold;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{data: 8'h96, amt: 3'd3, arith: 1'b0, hold: 1'b0, exp: 8'h12};
        vecs[1] = '{data: 8'h96, amt: 3'd3, arith: 1'b1, hold: 1'b0, exp: 8'hF2};
        vecs[2] = '{data: 8'h80, amt: 3'd7, arith: 1'b1, hold: 1'b0, exp: 8'hFF};
        vecs[3] = '{data: 8'h80, amt: 3'd7, arith: 1'b0, hold: 1'b0, exp: 8'h01};
        vecs[4] = '{data: 8'h5A, amt: 3'd0, arith: 1'b0, hold: 1'b0, exp: 8'h5A};
        vecs[5] = '{data: 8'h7F, amt: 3'd1, arith: 1'b1, hold: 1'b0, exp: 8'h3F};
        vecs[6] = '{data: 8'hC3, amt: 3'd2, arith: 1'b0, hold: 1'b0, exp: 8'h30};
        vecs[7] = '{data: 8'hC3, amt: 3'd2, arith: 1'b1, hold: 1'b0, exp: 8'hF0};
        vecs[8] = '{data: 8'h96, amt: 3'd3, arith: 1'b0, hold: 1'b1, exp: 8'h12};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        cmd_amt   = '0;
        cmd_arith = 1'b0;
        res_ready = 1'b1;
`ifdef SHIFT_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk_reset_values("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("idle cmd_ready", 32'(cmd_ready), 32'd1);

        // Directed vectors, including backpressure.
        for (int v = 0; v < 9; v++) begin
            exp_q.push_back(vecs[v].exp);
            run_cmd(vecs[v].data, vecs[v].amt, vecs[v].arith, vecs[v].hold,
                    $sformatf("vec%0d", v));
        end

        // Reset in the second SHIFT cycle: all outputs return to reset values
        // immediately, without waiting for a clock edge.
        res_ready = 1'b1;
        send_cmd(8'h96, 3'd6, 1'b1, "rst_mid");
        @(negedge clk); // k=1 LOAD
        cmd_valid = 1'b0;
        @(negedge clk); // k=2 first shift cycle
        chk("rst_mid in shift", 32'(sh_shift_right), 32'd1);
        @(negedge clk); // k=3 second shift cycle
        reset = 1'b1;
        #1;
        chk_reset_values("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(8'h03);
        run_cmd(8'h0F, 3'd2, 1'b0, 1'b0, "post_rst");

`ifdef SHIFT_SEQ_ABORT_EN
        // Abort during SHIFT returns to IDLE with no response.
        send_cmd(8'h96, 3'd5, 1'b1, "abort");
        @(negedge clk); // LOAD
        cmd_valid = 1'b0;
        @(negedge clk); // shift cycle 1
        @(negedge clk); // shift cycle 2
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort busy",        32'(busy),           32'd0);
        chk("abort load_n",      32'(sh_load_n),      32'd1);
        chk("abort shift_right", 32'(sh_shift_right), 32'd0);
        chk("abort asr",         32'(sh_asr),         32'd0);
        chk("abort load_val",    32'(sh_load_val),    32'd0);
        chk("abort cmd_ready",   32'(cmd_ready),      32'd1);
        begin
            bit any_valid;
            any_valid = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (res_valid) any_valid = 1'b1;
            end
            chk("abort no response", 32'(any_valid), 32'd0);
        end
        exp_q.push_back(8'hFF);
        run_cmd(8'hF0, 3'd4, 1'b1, 1'b0, "post_abort");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Command-driven controller for the team's 8-bit load/shift-right register (per-bit mux + DFF chain; arithmetic fill taken from load-value MSB).
- Accepts {operand, shift amount, arithmetic flag} over a valid/ready handshake, then drives the shifter's load/shift/ASR controls for the exact cycle count.
- Captures the shifter output and returns it over a second valid/ready handshake.
- Sits between a host FSM or switch-input front end and one shifter instance, which is clocked by the same clk.

Parameters:
- WIDTH, 8, operand/shifter width.
- AMT_W, 3, shift-amount width; legal amounts are 0..WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge; shared with the shifter.
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted on edge where cmd_valid && cmd_ready.
- cmd_data  input  WIDTH  operand.
- cmd_amt  input  AMT_W  number of right shifts.
- cmd_arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- sh_load_val  output  WIDTH  to shifter LoadVal.
- sh_load_n  output  1  to shifter Load_n, active-low load.
- sh_shift_right  output  1  to shifter ShiftRight.
- sh_asr  output  1  to shifter ASR.
- sh_q  input  WIDTH  shifter output q.
- res_valid  output  1  result available.
- res_ready  input  1  result consumed on edge where res_valid && res_ready.
- res_data  output  WIDTH  captured result.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, any state): state=IDLE, res_valid=0, res_data=0, sh_load_val=0, sh_load_n=1, sh_shift_right=0, sh_asr=0, busy=0, count=0. cmd_ready=0 while reset is high.
- All outputs are registered except cmd_ready = (state==IDLE) && !reset.
- States: IDLE, LOAD, SHIFT, CAPT, RESP.
- IDLE, on accept (edge E0): latch operand into sh_load_val, cmd_arith into sh_asr, cmd_amt into count. Drive sh_load_n=0. Go to LOAD.
- LOAD: sh_load_n=0, sh_shift_right=0. The shifter loads at E1. Next state is SHIFT if count!=0, else CAPT. sh_load_n returns to 1 from E1 onward.
- SHIFT: sh_shift_right=1 and sh_load_n=1. Decrement count each edge. Leave after exactly count edges (shifts occur at E2..E(N+1)), then go to CAPT with sh_shift_right=0.
- sh_load_val and sh_asr are held constant from E0 until return to IDLE. This is mandatory: the shifter's ASR fill bit comes from LoadVal[MSB], not q[MSB].
- CAPT: controls idle (load_n=1, shift=0). At E(N+2): res_data<=sh_q, res_valid<=1, go to RESP.
- RESP: res_valid=1, res_data stable. On res_valid && res_ready: res_valid<=0, go to IDLE. A new command cannot be accepted on that same edge; cmd_ready rises the following cycle.
- Latency: res_valid is first high after edge E(N+2), where E0 is the accepting edge and N=cmd_amt. Throughput: one command per N+4 cycles with res_ready tied high.
- cmd_amt is interpreted modulo 2^AMT_W. WIDTH-1 shifts yield all-sign (arith) or 0/1-LSB-of-MSB (logical) per shifter semantics.
- cmd_valid in non-IDLE states is ignored; the command is not lost as long as the host holds cmd_valid.
- Reset asserted mid-operation aborts with no response. The shifter's contents are don't-care after that.

Optional Feature:
- Macro SHIFT_SEQ_ABORT_EN.
- Defined: adds input abort (1 bit). If abort is sampled high in LOAD, SHIFT or CAPT, the next edge goes to IDLE with sh_load_n=1, sh_shift_right=0, sh_asr=0, sh_load_val=0, and no res_valid.
- Defined, abort in RESP or IDLE: ignored.
- Not defined: no abort port; behaviour is as above.

Test Plan:
- Bench shifter model: load when load_n=0 (priority), else shift right with fill = asr ? load_val[7] : 0.
- Logical: cmd_data=0x96, amt=3, arith=0, res_ready=1 -> res_data=0x12, res_valid high after E5, exactly 3 cycles with sh_shift_right=1.
- Arithmetic: 0x96, amt=3, arith=1 -> res_data=0xF2. Also 0x80, amt=7, arith=1 -> 0xFF.
- Zero amount: 0x5A, amt=0 -> 0x5A after E2, sh_shift_right never asserted.
- Backpressure: res_ready low 5 cycles -> res_valid and res_data=0x12 stable, cmd_ready=0, busy=1. Release -> IDLE next edge, cmd_ready=1 one cycle later.
- Reset mid-SHIFT (amt=6, reset on 2nd shift cycle) -> all outputs at reset values immediately (async). A following command 0x0F, amt=2, arith=0 -> 0x03.
- With SHIFT_SEQ_ABORT_EN: abort during SHIFT -> IDLE next edge, no res_valid. A following command 0xF0, amt=4, arith=1 -> 0xFF.
